// File: rtl/plb_wr_arbiter.sv
// Two-port arbiter sharing one PLB master write port: single-beat writes,
// round-robin or fixed priority, with a bus-side timeout against dead slaves.
module plb_wr_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 256,
  parameter int FIXED_PRIO = 0
) (
  input  logic              PLB_clk,
  input  logic              reset_n,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  output logic              r0_ack,
  output logic              r0_cmplt,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic              r1_ack,
  output logic              r1_cmplt,
  output logic              r1_err,
  output logic              IP2Bus_MstWr_Req,
  output logic [ADDR_W-1:0] IP2Bus_Mst_Addr,
  output logic [DATA_W-1:0] IP2Bus_MstWr_d,
  input  logic              Bus2IP_Mst_CmdAck,
  input  logic              Bus2IP_Mst_Cmplt,
  input  logic              Bus2IP_Mst_Error,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CMPLT, RELEASE} state_e;

  state_e            state_q, state_d;
  logic              busReq_q, busReq_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        cmplt_q, cmplt_d;
  logic [1:0]        err_q, err_d;
  logic              ptr_q, ptr_d;
  logic [CW-1:0]     tmoCnt_q, tmoCnt_d;
  logic              anyReq;
  logic              pick1;
  logic              tmoHit;

  // ptr_q set means port 1 is preferred on a tie; ignored under fixed priority.
  assign anyReq = r0_req | r1_req;
  assign pick1  = r1_req & (~r0_req | ((FIXED_PRIO == 0) & ptr_q));
  assign tmoHit = (TIMEOUT != 0) && (tmoCnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge PLB_clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (anyReq) state_d = ISSUE;
      ISSUE: begin
        if (Bus2IP_Mst_Cmplt)       state_d = RELEASE;
        else if (Bus2IP_Mst_CmdAck) state_d = WAIT_CMPLT;
        else if (tmoHit)            state_d = RELEASE;
      end
      WAIT_CMPLT: if (Bus2IP_Mst_Cmplt || tmoHit) state_d = RELEASE;
      RELEASE:    state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // A Cmplt seen in ISSUE stands in for the missing CmdAck; a real response
  // wins over a timeout landing in the same cycle.
  always_comb begin
    busReq_d = busReq_q;
    addr_d   = addr_q;
    data_d   = data_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    tmoCnt_d = tmoCnt_q;
    ack_d    = 2'b00;
    cmplt_d  = 2'b00;
    err_d    = 2'b00;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          busReq_d = 1'b1;
          grant_d  = pick1 ? 2'b10 : 2'b01;
          addr_d   = pick1 ? r1_addr : r0_addr;
          data_d   = pick1 ? r1_data : r0_data;
          tmoCnt_d = '0;
        end
      end
      ISSUE: begin
        tmoCnt_d = tmoCnt_q + CW'(1);
        if (Bus2IP_Mst_Cmplt) begin
          busReq_d = 1'b0;
          ack_d    = grant_q;
          cmplt_d  = grant_q;
          err_d    = Bus2IP_Mst_Error ? grant_q : 2'b00;
        end else if (Bus2IP_Mst_CmdAck) begin
          busReq_d = 1'b0;
          ack_d    = grant_q;
        end else if (tmoHit) begin
          busReq_d = 1'b0;
          ack_d    = grant_q;
          cmplt_d  = grant_q;
          err_d    = grant_q;
        end
      end
      WAIT_CMPLT: begin
        tmoCnt_d = tmoCnt_q + CW'(1);
        if (Bus2IP_Mst_Cmplt) begin
          cmplt_d = grant_q;
          err_d   = Bus2IP_Mst_Error ? grant_q : 2'b00;
        end else if (tmoHit) begin
          cmplt_d = grant_q;
          err_d   = grant_q;
        end
      end
      RELEASE: begin
        grant_d = 2'b00;
        ptr_d   = grant_q[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge PLB_clk or negedge reset_n) begin
    if (!reset_n) begin
      busReq_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      grant_q  <= 2'b00;
      ptr_q    <= 1'b0;
      tmoCnt_q <= '0;
      ack_q    <= 2'b00;
      cmplt_q  <= 2'b00;
      err_q    <= 2'b00;
    end else begin
      busReq_q <= busReq_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      tmoCnt_q <= tmoCnt_d;
      ack_q    <= ack_d;
      cmplt_q  <= cmplt_d;
      err_q    <= err_d;
    end
  end

  assign IP2Bus_MstWr_Req = busReq_q;
  assign IP2Bus_Mst_Addr  = addr_q;
  assign IP2Bus_MstWr_d   = data_q;
  assign grant            = grant_q;
  assign busy             = (state_q != IDLE);
  assign r0_ack           = ack_q[0];
  assign r1_ack           = ack_q[1];
  assign r0_cmplt         = cmplt_q[0];
  assign r1_cmplt         = cmplt_q[1];
  assign r0_err           = err_q[0];
  assign r1_err           = err_q[1];

endmodule
